// File: rtl/cpu_pkg.sv
// Shared CPU constants: register file geometry and write-back source indices.
package cpu_pkg;
    localparam int REG_AW   = 3;
    localparam int REG_DW   = 16;
    localparam int NUM_REGS = 8;
    localparam int WB_ALU   = 0;
    localparam int WB_LOAD  = 1;
    localparam int WB_MOV   = 2;
    localparam int WB_NSRC  = 3;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: owns the priority pointer, grants the first request at or after it.
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter int NREQ = WB_NSRC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gnt_idx
);
    logic [2:0] r_ptr;
    int         w_s;

    // Scan from lowest to highest priority so the slot at r_ptr wins last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_s     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_s = int'(r_ptr) + k;
            if (w_s >= NREQ) w_s = w_s - NREQ;
            if (req[w_s]) begin
                gnt      = '0;
                gnt[w_s] = 1'b1;
                gnt_idx  = 3'(w_s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: round-robin grant, registered write stage, r0 filter.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int NREQ       = WB_NSRC,
    parameter int DW         = REG_DW,
    parameter int AW         = REG_AW,
    parameter int PROTECT_R0 = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic [2:0]         grant_id,
    output logic [7:0]         drop_cnt
);
    logic [NREQ-1:0] w_req;
    logic [2:0]      w_idx;
    logic            w_xfer;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            w_drop;

    // No grants during freeze or while reset is asserted.
    assign w_req  = req_valid & {NREQ{~hold & rst_n}};
    assign w_xfer = |req_ready;
    assign w_drop = (PROTECT_R0 != 0) && w_xfer && (w_addr == '0);

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_req),
        .advance (w_xfer),
        .gnt     (req_ready),
        .gnt_idx (w_idx)
    );

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                w_addr = req_addr[i*AW +: AW];
                w_data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
            drop_cnt <= '0;
        end else begin
            wr_en <= w_xfer && !w_drop;
            if (w_xfer) grant_id <= w_idx;
            if (w_xfer && !w_drop) begin
                wr_addr <= w_addr;
                wr_data <= w_data;
            end
            if (w_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: two instances (r0 open / r0 protected) vs a behavioural model.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [8:0]  req_addr = '0;
    logic [47:0] req_data = '0;
    logic [2:0]  rdy0, rdy1, gid0, gid1;
    logic        we0, we1;
    logic [2:0]  wa0, wa1;
    logic [15:0] wd0, wd1;
    logic [7:0]  dc0, dc1;

    int tests = 0;
    int fails = 0;

    int          m_ptr;
    logic        m_we, m1_we;
    logic [2:0]  m_wa, m1_wa, m_gid;
    logic [15:0] m_wd, m1_wd;
    int          m_drop;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.PROTECT_R0(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid),
        .req_addr(req_addr), .req_data(req_data), .req_ready(rdy0),
        .wr_en(we0), .wr_addr(wa0), .wr_data(wd0), .grant_id(gid0),
        .drop_cnt(dc0)
    );

    regfile_wb_arbiter #(.PROTECT_R0(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid),
        .req_addr(req_addr), .req_data(req_data), .req_ready(rdy1),
        .wr_en(we1), .wr_addr(wa1), .wr_data(wd1), .grant_id(gid1),
        .drop_cnt(dc1)
    );

    function automatic void model_reset();
        m_ptr = 0; m_we = 0; m1_we = 0; m_wa = 0; m1_wa = 0;
        m_wd = 0; m1_wd = 0; m_gid = 0; m_drop = 0;
    endfunction

    function automatic int winner();
        if (hold || !rst_n) return -1;
        for (int k = 0; k < 3; k++)
            if (req_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        return -1;
    endfunction

    function automatic logic [2:0] exp_ready();
        int w;
        w = winner();
        return (w < 0) ? 3'b000 : 3'(1 << w);
    endfunction

    task automatic tick();
        int w;
        logic [2:0]  a;
        logic [15:0] d;
        w = winner();
        @(posedge clk);
        if (w >= 0) begin
            a = req_addr[w*3 +: 3];
            d = req_data[w*16 +: 16];
            m_we = 1; m_wa = a; m_wd = d; m_gid = 3'(w);
            m_ptr = (w + 1) % 3;
            if (a == 0) begin
                m1_we = 0;
                if (m_drop < 255) m_drop++;
            end else begin
                m1_we = 1; m1_wa = a; m1_wd = d;
            end
        end else begin
            m_we = 0; m1_we = 0;
        end
        #1;
    endtask

    task automatic set_src(input int i, input logic [2:0] a, input logic [15:0] d);
        req_addr[i*3 +: 3]  = a;
        req_data[i*16 +: 16] = d;
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        req_valid = 3'b111;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (rdy0 !== 3'b000) begin fails++; $display("FAIL reset_ready got %b exp 000", rdy0); end
        tests++; if (we0 !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b exp 0", we0); end
        tests++; if (wa0 !== 3'd0 || wd0 !== 16'd0) begin fails++; $display("FAIL reset_addr_data got %h/%h exp 0/0", wa0, wd0); end
        tests++; if (dc1 !== 8'd0 || gid0 !== 3'd0) begin fails++; $display("FAIL reset_drop_gid got %0d/%0d exp 0/0", dc1, gid0); end
        @(negedge clk);
        req_valid = 0;
        rst_n = 1;
        #1;
    endtask

    task automatic test_single();
        set_src(1, 3'd3, 16'h00AB);
        req_valid = 3'b010;
        #1;
        tests++; if (rdy0 !== 3'b010) begin fails++; $display("FAIL single_ready got %b exp 010", rdy0); end
        tick();
        req_valid = 0;
        tests++; if (we0 !== 1'b1 || wa0 !== 3'd3 || wd0 !== 16'h00AB || gid0 !== 3'd1)
            begin fails++; $display("FAIL single_write got en=%b a=%0d d=%h g=%0d exp 1/3/00ab/1", we0, wa0, wd0, gid0); end
        tick();
        tests++; if (we0 !== 1'b0 || wa0 !== 3'd3 || wd0 !== 16'h00AB)
            begin fails++; $display("FAIL single_idle got en=%b a=%0d d=%h exp 0/3/00ab", we0, wa0, wd0); end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 3; i++) set_src(i, 3'(i + 4), 16'h1000 + 16'(i));
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            tests++; if (rdy0 !== 3'(1 << (k % 3)))
                begin fails++; $display("FAIL contention_ready[%0d] got %b exp %b", k, rdy0, 3'(1 << (k % 3))); end
            tick();
            tests++; if (we0 !== 1'b1 || gid0 !== 3'(k % 3) || wd0 !== 16'h1000 + 16'(k % 3))
                begin fails++; $display("FAIL contention_write[%0d] got en=%b g=%0d d=%h", k, we0, gid0, wd0); end
        end
        req_valid = 0;
        tick();
    endtask

    task automatic test_hold();
        set_src(0, 3'd2, 16'h0202);
        set_src(2, 3'd7, 16'h0707);
        req_valid = 3'b001;
        tick();
        hold = 1;
        req_valid = 3'b100;
        #1;
        tests++; if (rdy0 !== 3'b000 || we0 !== 1'b1 || wd0 !== 16'h0202)
            begin fails++; $display("FAIL hold_inflight got rdy=%b en=%b d=%h exp 000/1/0202", rdy0, we0, wd0); end
        tick();
        tests++; if (rdy0 !== 3'b000 || we0 !== 1'b0)
            begin fails++; $display("FAIL hold_freeze got rdy=%b en=%b exp 000/0", rdy0, we0); end
        tick();
        hold = 0;
        #1;
        tests++; if (rdy0 !== 3'b100) begin fails++; $display("FAIL hold_release got %b exp 100", rdy0); end
        tick();
        req_valid = 0;
        tests++; if (we0 !== 1'b1 || gid0 !== 3'd2 || wa0 !== 3'd7)
            begin fails++; $display("FAIL hold_grant got en=%b g=%0d a=%0d exp 1/2/7", we0, gid0, wa0); end
    endtask

    task automatic test_r0();
        set_src(0, 3'd0, 16'hFFFF);
        req_valid = 3'b001;
        #1;
        tests++; if (rdy0[0] !== 1'b1 || rdy1[0] !== 1'b1)
            begin fails++; $display("FAIL r0_ready got %b/%b exp x01", rdy0, rdy1); end
        tick();
        req_valid = 0;
        tests++; if (we1 !== 1'b0 || dc1 !== 8'd1)
            begin fails++; $display("FAIL r0_protect got en=%b drop=%0d exp 0/1", we1, dc1); end
        tests++; if (we0 !== 1'b1 || wa0 !== 3'd0 || wd0 !== 16'hFFFF || dc0 !== 8'd0)
            begin fails++; $display("FAIL r0_open got en=%b a=%0d d=%h drop=%0d exp 1/0/ffff/0", we0, wa0, wd0, dc0); end
        tick();
    endtask

    task automatic test_random();
        bit          pv[3];
        logic [2:0]  pa[3];
        logic [15:0] pd[3];
        int          w;
        int          wait_cnt[3];
        for (int i = 0; i < 3; i++) begin pv[i] = 0; wait_cnt[i] = 0; end
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 3; i++) if (!pv[i] && $urandom_range(0, 2) != 0) begin
                pv[i] = 1;
                pa[i] = 3'($urandom_range(0, 7));
                pd[i] = 16'($urandom);
            end
            for (int i = 0; i < 3; i++) begin
                req_valid[i] = pv[i];
                set_src(i, pa[i], pd[i]);
            end
            hold = ($urandom_range(0, 7) == 0);
            #1;
            tests++; if (rdy0 !== exp_ready() || rdy1 !== exp_ready())
                begin fails++; $display("FAIL rand_ready[%0d] got %b/%b exp %b", c, rdy0, rdy1, exp_ready()); end
            w = winner();
            tick();
            for (int i = 0; i < 3; i++) begin
                if (pv[i] && i != w && !hold) wait_cnt[i]++;
                if (i == w) wait_cnt[i] = 0;
                tests++; if (wait_cnt[i] > 2)
                    begin fails++; $display("FAIL rand_starve[%0d] src %0d waited %0d", c, i, wait_cnt[i]); end
            end
            if (w >= 0) pv[w] = 0;
            tests++; if (we0 !== m_we || gid0 !== m_gid || (m_we && (wa0 !== m_wa || wd0 !== m_wd)))
                begin fails++; $display("FAIL rand_out0[%0d] got en=%b g=%0d a=%0d d=%h exp %b/%0d/%0d/%h", c, we0, gid0, wa0, wd0, m_we, m_gid, m_wa, m_wd); end
            tests++; if (we1 !== m1_we || wa1 !== m1_wa || wd1 !== m1_wd || dc1 !== 8'(m_drop))
                begin fails++; $display("FAIL rand_out1[%0d] got en=%b a=%0d d=%h drop=%0d exp %b/%0d/%h/%0d", c, we1, wa1, wd1, dc1, m1_we, m1_wa, m1_wd, m_drop); end
        end
        hold = 0;
        req_valid = 0;
        tick();
    endtask

    task automatic test_saturate();
        set_src(0, 3'd0, 16'h0);
        req_valid = 3'b001;
        repeat (260) tick();
        req_valid = 0;
        tests++; if (dc1 !== 8'd255 || m_drop != 255)
            begin fails++; $display("FAIL drop_saturate got %0d exp 255", dc1); end
        tests++; if (dc0 !== 8'd0 || we1 !== 1'b0)
            begin fails++; $display("FAIL drop_open got drop0=%0d en1=%b exp 0/0", dc0, we1); end
        tick();
    endtask

    task automatic test_async_reset();
        set_src(1, 3'd5, 16'h1234);
        req_valid = 3'b010;
        tick();
        set_src(2, 3'd6, 16'h5678);
        req_valid = 3'b100;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        tests++; if (we0 !== 1'b0 || wa0 !== 3'd0 || rdy0 !== 3'b000)
            begin fails++; $display("FAIL async_reset got en=%b a=%0d rdy=%b exp 0/0/000", we0, wa0, rdy0); end
        @(posedge clk);
        #1;
        tests++; if (we0 !== 1'b0 || wd0 !== 16'd0)
            begin fails++; $display("FAIL async_no_issue got en=%b d=%h exp 0/0000", we0, wd0); end
        @(negedge clk);
        rst_n = 1;
        req_valid = 3'b111;
        #1;
        tests++; if (rdy0 !== 3'b001) begin fails++; $display("FAIL async_ptr got %b exp 001", rdy0); end
        tick();
        req_valid = 0;
        tests++; if (gid0 !== 3'd0 || we0 !== 1'b1)
            begin fails++; $display("FAIL async_first got g=%0d en=%b exp 0/1", gid0, we0); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_hold();
        test_r0();
        test_random();
        test_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
